// File: rtl/if_stage_bpred_pkg.sv
// Shared types and constants for the fetch stage and its branch target buffer.
package if_stage_bpred_pkg;

  localparam int unsigned ENTRIES = 16;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned TAG_W   = 32 - IDX_W - 2;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // 2-bit direction counter states
  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [1:0]       ctr;
  } btb_entry_t;

endpackage

// File: rtl/if_stage_bpred_btb_2bit.sv
// Direct-mapped BTB with 2-bit saturating counters: combinational lookup,
// resolved-branch training and allocate-on-taken-miss.
module btb_2bit
  import if_stage_bpred_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_lookup_pc,
  output logic        o_pred_taken_c,
  output logic [31:0] o_target_c,
  input  logic        i_upd,
  input  logic [31:0] i_upd_pc,
  input  logic        i_upd_taken,
  input  logic [31:0] i_upd_target
);

  btb_entry_t r_btb [ENTRIES];

  logic [IDX_W-1:0] w_lidx;
  logic [IDX_W-1:0] w_uidx;
  btb_entry_t       w_lent;
  btb_entry_t       w_uent;
  btb_entry_t       w_new;
  logic             w_uhit;
  logic             w_we;
  logic             w_unused_bits;

  assign w_unused_bits = ^{i_lookup_pc[1:0], i_upd_pc[1:0]};

  // Lookup sees pre-update contents; a same-cycle write lands at the edge
  assign w_lidx         = i_lookup_pc[IDX_W+1:2];
  assign w_lent         = r_btb[w_lidx];
  assign o_pred_taken_c = w_lent.valid && (w_lent.tag == i_lookup_pc[31:IDX_W+2]) && w_lent.ctr[1];
  assign o_target_c     = w_lent.target;

  assign w_uidx = i_upd_pc[IDX_W+1:2];
  assign w_uent = r_btb[w_uidx];
  assign w_uhit = w_uent.valid && (w_uent.tag == i_upd_pc[31:IDX_W+2]);

  always_comb begin
    w_new = w_uent;
    w_we  = 1'b0;
    if (i_upd) begin
      if (w_uhit) begin
        w_we = 1'b1;
        if (i_upd_taken) begin
          w_new.target = i_upd_target;
          if (w_uent.ctr != ST) w_new.ctr = w_uent.ctr + 2'd1;
        end else if (w_uent.ctr != SNT) begin
          w_new.ctr = w_uent.ctr - 2'd1;
        end
      end else if (i_upd_taken) begin
        // Taken miss evicts whatever aliases into this slot
        w_we         = 1'b1;
        w_new.valid  = 1'b1;
        w_new.tag    = i_upd_pc[31:IDX_W+2];
        w_new.target = i_upd_target;
        w_new.ctr    = WT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        r_btb[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
      end
    end else if (w_we) begin
      r_btb[w_uidx] <= w_new;
    end
  end

endmodule

// File: rtl/if_stage_bpred.sv
// Instruction fetch stage: PC register, predicted next-PC selection and
// the IF/ID pipeline register, with EX/MEM redirect and BTB training.
module if_stage_bpred
  import if_stage_bpred_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        em_redirect,
  input  logic [31:0] em_redirect_pc,
  input  logic        em_update,
  input  logic [31:0] em_update_pc,
  input  logic        em_update_taken,
  input  logic [31:0] em_update_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_Instr,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_PC4,
  output logic        IF_pred_taken,
  output logic [31:0] IF_pred_target,
  output logic        IF_valid
);

  logic [31:0] r_pc;
  logic [31:0] w_pc4;
  logic [31:0] w_next_pc;
  logic [31:0] w_btb_target;
  logic        w_pred_taken;

  btb_2bit u_btb (
    .clk            (clk),
    .rst            (rst),
    .i_lookup_pc    (r_pc),
    .o_pred_taken_c (w_pred_taken),
    .o_target_c     (w_btb_target),
    .i_upd          (em_update),
    .i_upd_pc       (em_update_pc),
    .i_upd_taken    (em_update_taken),
    .i_upd_target   (em_update_target)
  );

  assign imem_addr = r_pc;
  assign w_pc4     = r_pc + 32'd4;

  // Redirect beats stall beats prediction beats sequential fetch
  always_comb begin
    w_next_pc = w_pc4;
    if (em_redirect)       w_next_pc = em_redirect_pc;
    else if (stall)        w_next_pc = r_pc;
    else if (w_pred_taken) w_next_pc = w_btb_target;
  end

  always_ff @(posedge clk) begin
    if (rst) r_pc <= RESET_PC;
    else     r_pc <= w_next_pc;
  end

  // A redirect also discards a stalled decode slot
  always_ff @(posedge clk) begin
    if (rst || em_redirect) begin
      IF_Instr       <= NOP_INSTR;
      IF_PC          <= 32'h0;
      IF_PC4         <= 32'h0;
      IF_pred_taken  <= 1'b0;
      IF_pred_target <= 32'h0;
      IF_valid       <= 1'b0;
    end else if (!stall) begin
      IF_Instr       <= imem_rdata;
      IF_PC          <= r_pc;
      IF_PC4         <= w_pc4;
      IF_pred_taken  <= w_pred_taken;
      IF_pred_target <= w_btb_target;
      IF_valid       <= 1'b1;
    end
  end

endmodule
